// File: rtl/link_tx_scheduler.sv
// Arbitrates paddle/ball/score requesters onto one UART TX byte channel and
// frames each grant as header, payload and XOR checksum, followed by an idle gap.
module link_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  HDR_BASE   = 8'hA0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_paddle,
  input  logic [9:0]  y_paddle,
  input  logic        req_ball,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  input  logic        req_score,
  input  logic [3:0]  player1_score,
  input  logic [3:0]  player2_score,
  output logic        gnt_paddle,
  output logic        gnt_ball,
  output logic        gnt_score,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_CHK  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic [7:0] chk_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          state_r, state_s;
  logic [7:0]      tx_data_r, tx_data_s;
  logic            tx_valid_r, tx_valid_s;
  logic            busy_r, busy_s;
  logic            gnt_paddle_r, gnt_paddle_s;
  logic            gnt_ball_r, gnt_ball_s;
  logic            gnt_score_r, gnt_score_s;
  logic [7:0]      chk_r, chk_s;
  logic [GW-1:0]   gap_cnt_r, gap_cnt_s;
  logic            rr_ball_r, rr_ball_s;     // 1: ball wins a paddle/ball tie
  logic [3:0][7:0] pay_r, pay_s;
  logic [1:0]      pay_last_r, pay_last_s;
  logic [1:0]      idx_r, idx_s;
  logic [1:0]      idx_inc_s;
  logic [1:0]      type_s;
  logic [7:0]      hdr_s;

  // Next-state, arbitration and byte sequencing
  always_comb begin
    state_s     = state_r;
    tx_data_s   = tx_data_r;
    tx_valid_s  = tx_valid_r;
    busy_s      = busy_r;
    gnt_paddle_s = 1'b0;
    gnt_ball_s  = 1'b0;
    gnt_score_s = 1'b0;
    chk_s       = chk_r;
    gap_cnt_s   = gap_cnt_r;
    rr_ball_s   = rr_ball_r;
    pay_s       = pay_r;
    pay_last_s  = pay_last_r;
    idx_s       = idx_r;
    idx_inc_s   = idx_r + 2'd1;
    type_s      = 2'd0;
    hdr_s       = HDR_BASE;

    case (state_r)
      S_IDLE: begin
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
        if (en && (req_score || req_paddle || req_ball)) begin
          if (req_score) begin
            gnt_score_s = 1'b1;
            type_s      = 2'd3;
            pay_s       = {8'h00, 8'h00, 8'h00, {player1_score, player2_score}};
            pay_last_s  = 2'd0;
          end else if (req_paddle && (!req_ball || !rr_ball_r)) begin
            gnt_paddle_s = 1'b1;
            type_s       = 2'd1;
            pay_s        = {8'h00, 8'h00, y_paddle[7:0], {6'b000000, y_paddle[9:8]}};
            pay_last_s   = 2'd1;
            rr_ball_s    = 1'b1;
          end else begin
            gnt_ball_s = 1'b1;
            type_s     = 2'd2;
            pay_s      = {y_ball[7:0], {6'b000000, y_ball[9:8]},
                          x_ball[7:0], {5'b00000, x_ball[10:8]}};
            pay_last_s = 2'd3;
            rr_ball_s  = 1'b0;
          end
          hdr_s      = HDR_BASE | {6'b000000, type_s};
          tx_data_s  = hdr_s;
          chk_s      = hdr_s;
          tx_valid_s = 1'b1;
          busy_s     = 1'b1;
          idx_s      = 2'd0;
          state_s    = S_HDR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (tx_ready) begin
          tx_data_s = pay_r[0];
          chk_s     = chk_acc(chk_r, pay_r[0]);
          idx_s     = 2'd0;
          state_s   = S_PAY;
        end else begin
          state_s = S_HDR;
        end
      end
      S_PAY: begin
        // chk_r already folds in the byte on the wire, so it is the checksum
        if (tx_ready) begin
          if (idx_r == pay_last_r) begin
            tx_data_s = chk_r;
            state_s   = S_CHK;
          end else begin
            tx_data_s = pay_r[idx_inc_s];
            chk_s     = chk_acc(chk_r, pay_r[idx_inc_s]);
            idx_s     = idx_inc_s;
            state_s   = S_PAY;
          end
        end else begin
          state_s = S_PAY;
        end
      end
      S_CHK: begin
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          tx_data_s  = 8'h00;
          gap_cnt_s  = {GW{1'b0}};
          state_s    = S_GAP;
        end else begin
          state_s = S_CHK;
        end
      end
      S_GAP: begin
        tx_valid_s = 1'b0;
        if (gap_cnt_r == GAP_LAST) begin
          busy_s    = 1'b0;
          gap_cnt_s = {GW{1'b0}};
          state_s   = S_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
          state_s   = S_GAP;
        end
      end
      default: begin
        tx_valid_s = 1'b0;
        busy_s     = 1'b0;
        state_s    = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      tx_data_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      gnt_paddle_r <= 1'b0;
      gnt_ball_r   <= 1'b0;
      gnt_score_r  <= 1'b0;
      chk_r        <= 8'h00;
      gap_cnt_r    <= {GW{1'b0}};
      rr_ball_r    <= 1'b0;
      pay_r        <= {4{8'h00}};
      pay_last_r   <= 2'd0;
      idx_r        <= 2'd0;
    end else begin
      state_r      <= state_s;
      tx_data_r    <= tx_data_s;
      tx_valid_r   <= tx_valid_s;
      busy_r       <= busy_s;
      gnt_paddle_r <= gnt_paddle_s;
      gnt_ball_r   <= gnt_ball_s;
      gnt_score_r  <= gnt_score_s;
      chk_r        <= chk_s;
      gap_cnt_r    <= gap_cnt_s;
      rr_ball_r    <= rr_ball_s;
      pay_r        <= pay_s;
      pay_last_r   <= pay_last_s;
      idx_r        <= idx_s;
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign gnt_paddle = gnt_paddle_r;
  assign gnt_ball   = gnt_ball_r;
  assign gnt_score  = gnt_score_r;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler: expected grants and bytes are queued when
// requests are driven and compared as the DUT hands bytes to the UART side.
module tb_link_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        req_paddle, req_ball, req_score;
  logic [9:0]  y_paddle, y_ball;
  logic [10:0] x_ball;
  logic [3:0]  player1_score, player2_score;
  logic        gnt_paddle, gnt_ball, gnt_score;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  sb[$];
  logic [2:0]  gq[$];
  logic        hold_pending = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  always #5 clk = ~clk;

  link_tx_scheduler dut (
    .clk(clk), .rst(rst), .en(en),
    .req_paddle(req_paddle), .y_paddle(y_paddle),
    .req_ball(req_ball), .x_ball(x_ball), .y_ball(y_ball),
    .req_score(req_score), .player1_score(player1_score), .player2_score(player2_score),
    .gnt_paddle(gnt_paddle), .gnt_ball(gnt_ball), .gnt_score(gnt_score),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_paddle(input logic [9:0] y);
    gq.push_back(3'b001);
    sb.push_back(8'hA1);
    sb.push_back({6'b000000, y[9:8]});
    sb.push_back(y[7:0]);
    sb.push_back(8'hA1 ^ {6'b000000, y[9:8]} ^ y[7:0]);
  endtask

  task automatic push_ball(input logic [10:0] x, input logic [9:0] y);
    gq.push_back(3'b010);
    sb.push_back(8'hA2);
    sb.push_back({5'b00000, x[10:8]});
    sb.push_back(x[7:0]);
    sb.push_back({6'b000000, y[9:8]});
    sb.push_back(y[7:0]);
    sb.push_back(8'hA2 ^ {5'b00000, x[10:8]} ^ x[7:0] ^ {6'b000000, y[9:8]} ^ y[7:0]);
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rising edge
  task automatic cycle();
    logic [2:0] g;
    @(negedge clk);
    if (hold_pending) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'(hold_data));
    end
    hold_pending = 1'b0;
    if (tx_valid === 1'b1) begin
      if (tx_ready) begin
        chk("byte_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
      end else begin
        hold_pending = 1'b1;
        hold_data    = tx_data;
      end
    end
    g = {gnt_score, gnt_ball, gnt_paddle};
    if (g !== 3'b000) begin
      chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
      if (gq.size() != 0) chk("gnt", 32'(g), 32'(gq.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b1; tx_ready = 1'b1;
    req_paddle = 1'b0; req_ball = 1'b0; req_score = 1'b0;
    y_paddle = 10'h000; x_ball = 11'h000; y_ball = 10'h000;
    player1_score = 4'h0; player2_score = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({gnt_score, gnt_ball, gnt_paddle}), 32'd0);
    rst = 1'b1;
    cycle();
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);

    // Paddle packet with its gap
    y_paddle = 10'h2AB; req_paddle = 1'b1;
    gq.push_back(3'b001);
    sb.push_back(8'hA1); sb.push_back(8'h02); sb.push_back(8'hAB); sb.push_back(8'h08);
    cycle();
    req_paddle = 1'b0;
    chk("hdr_latency_valid", 32'(tx_valid), 32'd1);
    chk("hdr_latency_data", 32'(tx_data), 32'hA1);
    drain(40);
    for (int i = 0; i < 16; i++) begin
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_valid", 32'(tx_valid), 32'd0);
      cycle();
    end
    chk("gap_end_busy", 32'(busy), 32'd0);

    // Ball packet; inputs change right after the grant
    x_ball = 11'h5A3; y_ball = 10'h1F0; req_ball = 1'b1;
    gq.push_back(3'b010);
    sb.push_back(8'hA2); sb.push_back(8'h05); sb.push_back(8'hA3);
    sb.push_back(8'h01); sb.push_back(8'hF0); sb.push_back(8'hF5);
    cycle();
    req_ball = 1'b0; x_ball = 11'h7FF; y_ball = 10'h000;
    drain(40);
    wait_idle(40);

    // Ball packet under random backpressure
    x_ball = 11'h3C4; y_ball = 10'h2E1; req_ball = 1'b1;
    push_ball(11'h3C4, 10'h2E1);
    cycle();
    req_ball = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tx_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    tx_ready = 1'b1;
    chk("bp_drain", 32'(sb.size()), 32'd0);
    wait_idle(40);

    // Score priority, then paddle/ball round robin while held
    player1_score = 4'd3; player2_score = 4'd7;
    y_paddle = 10'h155; x_ball = 11'h2AA; y_ball = 10'h0CC;
    gq.push_back(3'b100);
    sb.push_back(8'hA3); sb.push_back(8'h37); sb.push_back(8'h94);
    push_paddle(10'h155); push_ball(11'h2AA, 10'h0CC);
    push_paddle(10'h155); push_ball(11'h2AA, 10'h0CC);
    req_score = 1'b1; req_paddle = 1'b1; req_ball = 1'b1;
    cycle();
    req_score = 1'b0;
    drain(300);
    req_score = 1'b1;
    gq.push_back(3'b100);
    sb.push_back(8'hA3); sb.push_back(8'h37); sb.push_back(8'h94);
    n = 0;
    while (gnt_score !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    chk("score_regrant", 32'(gnt_score), 32'd1);
    req_score = 1'b0; req_paddle = 1'b0; req_ball = 1'b0;
    drain(40);
    wait_idle(40);

    // Reset during payload, then a fresh packet from the header
    x_ball = 11'h111; y_ball = 10'h222; req_ball = 1'b1;
    push_ball(11'h111, 10'h222);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sb.delete(); gq.delete(); hold_pending = 1'b0;
    cycle();
    push_ball(11'h111, 10'h222);
    rst = 1'b1;
    cycle();
    req_ball = 1'b0;
    chk("postrst_valid", 32'(tx_valid), 32'd1);
    chk("postrst_hdr", 32'(tx_data), 32'hA2);
    drain(40);
    wait_idle(40);

    // Link disabled during the header: packet completes, no further grants
    y_paddle = 10'h0F3; req_paddle = 1'b1;
    push_paddle(10'h0F3);
    cycle();
    en = 1'b0;
    drain(40);
    wait_idle(40);
    repeat (10) cycle();
    chk("en_off_busy", 32'(busy), 32'd0);
    chk("en_off_valid", 32'(tx_valid), 32'd0);
    push_paddle(10'h0F3);
    en = 1'b1;
    cycle();
    chk("en_on_gnt", 32'(gnt_paddle), 32'd1);
    req_paddle = 1'b0;
    drain(40);
    wait_idle(40);
    chk("grants_left", 32'(gq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Shares the single UART transmit byte channel of the two-board link among three requesters: paddle position, ball position and score.
- Grants one requester at a time and captures its data at grant.
- Serialises the data as a framed packet: header, payload, XOR checksum.
- Enforces a minimum idle gap between packets.
- Sits between the game-logic state and the UART TX byte interface that drives the link pin.

Parameters:
- GAP_CYCLES, 16: idle clk cycles after a checksum byte is accepted before the next arbitration (≥1).
- HDR_BASE, 8'hA0: header upper nibble; header = HDR_BASE | type.

Ports:
- clk  in  1  system clock (65 MHz domain).
- rst  in  1  asynchronous, active-low reset.
- en  in  1  link enable; low blocks new grants but lets the in-flight packet finish.
- req_paddle  in  1  level request for a paddle packet.
- y_paddle  in  10  paddle y; sampled on the grant cycle.
- req_ball  in  1  level request for a ball packet.
- x_ball  in  11  ball x; sampled on the grant cycle.
- y_ball  in  10  ball y; sampled on the grant cycle.
- req_score  in  1  level request for a score packet.
- player1_score  in  4  sampled on the grant cycle.
- player2_score  in  4  sampled on the grant cycle.
- gnt_paddle, gnt_ball, gnt_score  out  1 each  one-cycle grant pulse; the requester may drop req after it.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART TX accepts the byte; a transfer occurs when tx_valid && tx_ready at a rising clk edge.
- busy  out  1  high from grant through the end of GAP.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; tx_valid=0, tx_data=0, all gnt=0, busy=0, checksum=0, gap counter=0, RR pointer=paddle.
- States and transitions:
  - IDLE → HDR when en=1 and any req=1.
  - HDR → PAY when header byte accepted.
  - PAY → CHK when last payload byte accepted.
  - CHK → GAP when checksum accepted.
  - GAP → IDLE after GAP_CYCLES cycles.
- Arbitration (IDLE only):
  - req_score has fixed highest priority.
  - Paddle vs ball is round-robin: the pointer moves to the other one after a paddle or ball grant; a score grant leaves it unchanged.
  - Winner's gnt pulses for exactly one cycle on the IDLE→HDR edge.
  - Its data is registered in the same edge.
  - tx_valid=1 with the header from the next cycle. Latency from req sampled high in IDLE to header valid: 1 cycle.
- Packet formats (bytes in order, after header):
  - Paddle, type 1: {6'b0,y[9:8]}, y[7:0].
  - Ball, type 2: {5'b0,x[10:8]}, x[7:0], {6'b0,y[9:8]}, y[7:0].
  - Score, type 3: {player1_score, player2_score}.
- Checksum byte = XOR of header and all payload bytes.
- Payload byte counter width: 2 bits.
- Backpressure:
  - While tx_valid=1 && tx_ready=0, tx_data and state hold stable.
  - tx_valid never deasserts mid-packet.
  - The next byte is presented in the cycle after acceptance, so tx_valid stays high continuously HDR..CHK if tx_ready=1.
- Captured data is immune to input changes after grant.
- en drop mid-packet: the packet completes, including GAP; then the block stays in IDLE until en=1.
- Requests arriving during HDR..GAP are not lost if held; they are evaluated in IDLE.
- Simultaneous req_paddle and req_ball: the RR pointer decides. Simultaneous all three: score wins.
- tx_valid=0 in IDLE and GAP.

Test Plan:
- Paddle: req_paddle=1, y_paddle=10'h2AB, tx_ready=1 → gnt_paddle pulse; bytes A1,02,AB,08; then 16 idle cycles with busy=1, tx_valid=0.
- Ball: x_ball=11'h5A3, y_ball=10'h1F0 → bytes A2,05,A3,01,F0,F5. Changing x_ball after the grant does not alter the bytes.
- Score priority: all three req high after reset → score packet A3,37,94 (p1=3, p2=7) first. Then paddle, ball, paddle, ball… alternating while held, with score re-winning whenever req_score is high.
- Backpressure: tx_ready toggled 0/1 randomly during a ball packet → same 6 bytes, each stable while tx_ready=0, no duplicates or drops.
- Reset mid-packet: rst=0 during PAY → immediately tx_valid=0, busy=0. After release with requests held, a fresh header (not a stale payload) is sent.
- en=0 asserted during HDR of a paddle packet → packet completes, then no further grants despite held requests. en=1 → next grant in the following IDLE cycle.
